// File: rtl/text_mem_scheduler_pkg.sv
// Shared definitions for the text RAM write-port scheduler: default RAM
// geometry (also used by the command decoder and the RAM wrapper) and the
// fill engine state encoding.
package text_mem_scheduler_pkg;

    localparam int TEXT_ADDR_W = 12;
    localparam int TEXT_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/text_mem_scheduler_fill_engine.sv
// Block-fill engine: latches a fill request and walks the address range,
// offering one write per cycle through fill_req/fill_addr/fill_wdata.
// The top grants the port with fill_grant; the engine advances only on grant.
// Optional macro TEXT_FILL_STRIDE_EN adds fill_stride (otherwise step is 1).
//
//  state | meaning
//  IDLE  | waiting for fill_start
//  FILL  | offering writes, advancing on each grant
//  DONE  | last write issued; pulse fill_done and return to IDLE
module text_mem_scheduler_fill_engine
    import text_mem_scheduler_pkg::*;
#(
    parameter int ADDR_W = TEXT_ADDR_W,
    parameter int DATA_W = TEXT_DATA_W
) (
    input  logic              cpu_clock,
    input  logic              reset_n,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_data,
`ifdef TEXT_FILL_STRIDE_EN
    input  logic [ADDR_W-1:0] fill_stride,
`endif
    input  logic              fill_grant,
    output logic              fill_req,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_wdata,
    output logic              fill_busy,
    output logic              fill_done
);

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    fill_state_t       state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] step;

`ifdef TEXT_FILL_STRIDE_EN
    logic [ADDR_W-1:0] step_q;

    // Stride is captured together with the other fill parameters.
    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            step_q <= '0;
        end else if (state == ST_IDLE && fill_start && fill_len != '0) begin
            step_q <= fill_stride;
        end
    end

    assign step = step_q;
`else
    assign step = ADDR_ONE;
`endif

    assign fill_req   = (state == ST_FILL);
    assign fill_addr  = cur_addr;
    assign fill_wdata = data_q;

    // Fill FSM: parameter latch, address/count walk and status outputs.
    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            len_q     <= '0;
            cnt       <= '0;
            data_q    <= '0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fill_start) begin
                        if (fill_len != '0) begin
                            cur_addr  <= fill_base;
                            len_q     <= fill_len;
                            data_q    <= fill_data;
                            cnt       <= '0;
                            fill_busy <= 1'b1;
                            state     <= ST_FILL;
                        end else begin
                            // Zero-length fill completes immediately.
                            fill_done <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (fill_grant) begin
                        cnt      <= cnt + CNT_ONE;
                        cur_addr <= cur_addr + step;
                        if (cnt == len_q - CNT_ONE) begin
                            fill_busy <= 1'b0;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Lands one cycle after the last write shows on mem_*.
                    fill_done <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/text_mem_scheduler.sv
// Owns port A (write port) of the text RAM in the cpu_clock domain.
// Arbitrates between single-word command writes (strict priority) and the
// block-fill engine, and registers every RAM-facing output.
// Optional macro TEXT_FILL_STRIDE_EN adds the fill_stride port.
module text_mem_scheduler
    import text_mem_scheduler_pkg::*;
#(
    parameter int ADDR_W = TEXT_ADDR_W,
    parameter int DATA_W = TEXT_DATA_W
) (
    input  logic              cpu_clock,
    input  logic              reset_n,
    input  logic              cmd_req,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cmd_ack,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_data,
`ifdef TEXT_FILL_STRIDE_EN
    input  logic [ADDR_W-1:0] fill_stride,
`endif
    output logic              fill_busy,
    output logic              fill_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data
);

    logic              cmd_grant;
    logic              fill_grant;
    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_wdata;

    // A held request is not re-granted in its ack cycle, so one req = one write.
    assign cmd_grant  = cmd_req & ~cmd_ack;
    assign fill_grant = fill_req & ~cmd_grant;

    text_mem_scheduler_fill_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill (
        .cpu_clock  (cpu_clock),
        .reset_n    (reset_n),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_data  (fill_data),
`ifdef TEXT_FILL_STRIDE_EN
        .fill_stride(fill_stride),
`endif
        .fill_grant (fill_grant),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_wdata (fill_wdata),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    // Output stage: the grant decided this cycle drives the RAM next cycle.
    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ack  <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            cmd_ack <= cmd_grant;
            mem_en  <= cmd_grant | fill_grant;
            mem_we  <= cmd_grant | fill_grant;
            if (cmd_grant) begin
                mem_addr <= cmd_addr;
                mem_data <= cmd_data;
            end else if (fill_grant) begin
                mem_addr <= fill_addr;
                mem_data <= fill_wdata;
            end else begin
                mem_addr <= '0;
                mem_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_text_mem_scheduler.sv
// Bench for text_mem_scheduler: table-driven command and fill vectors, a
// write scoreboard fed by the stimulus, and hand-written corner sequences.
module tb_text_mem_scheduler;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          cpu_clock = 1'b0;
    logic          reset_n;
    logic          cmd_req;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          cmd_ack;
    logic          fill_start;
    logic [AW-1:0] fill_base;
    logic [AW:0]   fill_len;
    logic [DW-1:0] fill_data;
`ifdef TEXT_FILL_STRIDE_EN
    logic [AW-1:0] fill_stride;
`endif
    logic          fill_busy;
    logic          fill_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;

    text_mem_scheduler dut (
        .cpu_clock  (cpu_clock),
        .reset_n    (reset_n),
        .cmd_req    (cmd_req),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_ack    (cmd_ack),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_data  (fill_data),
`ifdef TEXT_FILL_STRIDE_EN
        .fill_stride(fill_stride),
`endif
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data)
    );

    always #5 cpu_clock = ~cpu_clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            exp_lat;
    } cmd_vec_t;

    typedef struct packed {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        logic [DW-1:0] data;
        logic [AW-1:0] exp_last;
        int            exp_writes;
    } fill_vec_t;

    wr_t      exp_q[$];
    int       ack_cycles[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       n_writes = 0;
    int       n_done = 0;
    int       n_acks = 0;
    int       busy_cycles = 0;
    int       last_wr_cyc = 0;
    int       done_cyc = 0;
    logic [AW-1:0] last_wr_addr = '0;

    always @(posedge cpu_clock) cyc++;

    // Scoreboard / monitor, sampled away from the active edge.
    always @(negedge cpu_clock) begin
        wr_t e;
        checks++;
        if (mem_we !== mem_en) begin
            errors++;
            $display("FAIL we_eq_en cyc=%0d got we=%b en=%b", cyc, mem_we, mem_en);
        end
        if (mem_en === 1'b1) begin
            n_writes++;
            last_wr_cyc  = cyc;
            last_wr_addr = mem_addr;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc=%0d got addr=%h data=%h expected none", cyc, mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_data !== e.data) begin
                    errors++;
                    $display("FAIL write cyc=%0d got addr=%h data=%h expected addr=%h data=%h",
                             cyc, mem_addr, mem_data, e.addr, e.data);
                end
            end
        end
        if (cmd_ack === 1'b1) begin
            n_acks++;
            ack_cycles.push_back(cyc);
        end
        if (fill_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (fill_busy === 1'b1) busy_cycles++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clock);
        #1;
    endtask

    task automatic push_fill(input logic [AW-1:0] base, input int len,
                             input logic [DW-1:0] data, input logic [AW-1:0] step);
        logic [AW-1:0] a;
        a = base;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({a, data});
            a = a + step;
        end
    endtask

    task automatic do_fill(input logic [AW-1:0] base, input logic [AW:0] len,
                           input logic [DW-1:0] data);
        fill_base  = base;
        fill_len   = len;
        fill_data  = data;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int k;
        k = 0;
        while ((fill_busy === 1'b1 || exp_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            errors++;
            $display("FAIL timeout_%s got %0d cycles expected under %0d", name, k, budget);
        end
        repeat (3) tick();
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_mem_en"},    mem_en,    0);
        chk({name, "_mem_we"},    mem_we,    0);
        chk({name, "_mem_addr"},  mem_addr,  0);
        chk({name, "_mem_data"},  mem_data,  0);
        chk({name, "_cmd_ack"},   cmd_ack,   0);
        chk({name, "_fill_busy"}, fill_busy, 0);
        chk({name, "_fill_done"}, fill_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got time=%0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_vec_t  cmd_tab [4];
        fill_vec_t fill_tab[4];
        int w0, d0, b0, a0, t0, ack_cnt, k;

        cmd_tab[0] = '{addr: 12'h000, data: 16'hFFFF, exp_lat: 1};
        cmd_tab[1] = '{addr: 12'hFFF, data: 16'h0001, exp_lat: 1};
        cmd_tab[2] = '{addr: 12'h5A5, data: 16'hA5A5, exp_lat: 1};
        cmd_tab[3] = '{addr: 12'h123, data: 16'h0741, exp_lat: 1};

        fill_tab[0] = '{base: 12'h010, len: 13'd1,    data: 16'h1111, exp_last: 12'h010, exp_writes: 1};
        fill_tab[1] = '{base: 12'hFFE, len: 13'd3,    data: 16'h2222, exp_last: 12'h000, exp_writes: 3};
        fill_tab[2] = '{base: 12'h800, len: 13'd5,    data: 16'h3333, exp_last: 12'h804, exp_writes: 5};
        fill_tab[3] = '{base: 12'h005, len: 13'd4096, data: 16'h0F20, exp_last: 12'h004, exp_writes: 4096};

        reset_n    = 1'b0;
        cmd_req    = 1'b0;
        cmd_addr   = '0;
        cmd_data   = '0;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_len   = '0;
        fill_data  = '0;
`ifdef TEXT_FILL_STRIDE_EN
        fill_stride = 12'd1;
`endif
        repeat (3) tick();
        chk_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (2) tick();

        // Single command writes from the table.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({cmd_tab[i].addr, cmd_tab[i].data});
            cmd_addr = cmd_tab[i].addr;
            cmd_data = cmd_tab[i].data;
            cmd_req  = 1'b1;
            t0 = cyc;
            k  = 0;
            do begin
                tick();
                k++;
            end while (cmd_ack !== 1'b1 && k < 10);
            chk("cmd_latency", cyc - t0, cmd_tab[i].exp_lat);
            cmd_req = 1'b0;
            tick();
        end
        wait_quiet(20, "cmd_table");
        chk("cmd_table_drained", exp_q.size(), 0);

        // Held request: 6 cycles -> 3 writes, acks 2 cycles apart.
        a0 = n_acks;
        w0 = n_writes;
        ack_cycles.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back({12'h123, 16'h0741});
        cmd_addr = 12'h123;
        cmd_data = 16'h0741;
        cmd_req  = 1'b1;
        t0 = cyc;
        repeat (6) tick();
        cmd_req = 1'b0;
        repeat (3) tick();
        chk("held_acks", n_acks - a0, 3);
        chk("held_writes", n_writes - w0, 3);
        chk("held_ack_count", ack_cycles.size(), 3);
        if (ack_cycles.size() == 3) begin
            chk("held_first_ack", ack_cycles[0] - t0, 1);
            chk("held_gap1", ack_cycles[1] - ack_cycles[0], 2);
            chk("held_gap2", ack_cycles[2] - ack_cycles[1], 2);
        end

        // Simple 2400-word fill with no command traffic.
        w0 = n_writes;
        d0 = n_done;
        b0 = busy_cycles;
        push_fill(12'h000, 2400, 16'h0720, 12'd1);
        do_fill(12'h000, 13'd2400, 16'h0720);
        wait_quiet(3000, "simple_fill");
        chk("simple_writes", n_writes - w0, 2400);
        chk("simple_busy_cycles", busy_cycles - b0, 2400);
        chk("simple_done_pulses", n_done - d0, 1);
        chk("simple_done_timing", done_cyc - last_wr_cyc, 1);
        chk("simple_last_addr", last_wr_addr, 2399);

        // Fill table: lengths 1, wrap at top, mid range, full memory.
        for (int i = 0; i < 4; i++) begin
            w0 = n_writes;
            d0 = n_done;
            push_fill(fill_tab[i].base, int'(fill_tab[i].len), fill_tab[i].data, 12'd1);
            do_fill(fill_tab[i].base, fill_tab[i].len, fill_tab[i].data);
            wait_quiet(int'(fill_tab[i].len) + 50, "fill_table");
            chk("fill_tab_writes", n_writes - w0, fill_tab[i].exp_writes);
            chk("fill_tab_last", last_wr_addr, fill_tab[i].exp_last);
            chk("fill_tab_done", n_done - d0, 1);
            chk("fill_tab_timing", done_cyc - last_wr_cyc, 1);
        end

        // Contention: continuous cmd_req plus fill at 0xFFC, same start cycle.
        w0 = n_writes;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({12'h200, 16'hAAAA});
            exp_q.push_back({12'hFFC + 12'(i), 16'h1E41});
        end
        cmd_addr = 12'h200;
        cmd_data = 16'hAAAA;
        cmd_req  = 1'b1;
        do_fill(12'hFFC, 13'd8, 16'h1E41);
        ack_cnt = 0;
        k = 0;
        while (ack_cnt < 8 && k < 40) begin
            if (cmd_ack === 1'b1) ack_cnt++;
            if (ack_cnt < 8) tick();
            k++;
        end
        chk("contention_acks", ack_cnt, 8);
        cmd_req = 1'b0;
        wait_quiet(40, "contention");
        chk("contention_writes", n_writes - w0, 16);
        chk("contention_drained", exp_q.size(), 0);

        // Zero-length fill: done pulse next cycle, no writes.
        w0 = n_writes;
        d0 = n_done;
        t0 = cyc;
        do_fill(12'h040, 13'd0, 16'h9999);
        repeat (3) tick();
        chk("len0_done", n_done - d0, 1);
        chk("len0_done_timing", done_cyc - t0, 1);
        chk("len0_writes", n_writes - w0, 0);

        // fill_start while busy is ignored.
        w0 = n_writes;
        d0 = n_done;
        push_fill(12'h300, 4, 16'h4444, 12'd1);
        do_fill(12'h300, 13'd4, 16'h4444);
        do_fill(12'h500, 13'd10, 16'h5555);
        wait_quiet(40, "busy_restart");
        chk("busy_restart_writes", n_writes - w0, 4);
        chk("busy_restart_done", n_done - d0, 1);
        chk("busy_restart_last", last_wr_addr, 12'h303);

        // Reset mid-fill (cnt=5 of 20).
        w0 = n_writes;
        d0 = n_done;
        push_fill(12'h100, 5, 16'h0101, 12'd1);
        do_fill(12'h100, 13'd20, 16'h0101);
        repeat (5) tick();
        @(negedge cpu_clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("midfill_async");
        tick();
        chk_outputs_zero("midfill_edge");
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("midfill_writes", n_writes - w0, 5);
        chk("midfill_no_done", n_done - d0, 0);
        chk("midfill_drained", exp_q.size(), 0);
        chk("midfill_busy", fill_busy, 0);

`ifdef TEXT_FILL_STRIDE_EN
        // Column fill with stride 80.
        w0 = n_writes;
        fill_stride = 12'd80;
        push_fill(12'd5, 30, 16'h077C, 12'd80);
        do_fill(12'd5, 13'd30, 16'h077C);
        wait_quiet(80, "stride");
        chk("stride_writes", n_writes - w0, 30);
        chk("stride_last", last_wr_addr, 2325);
        fill_stride = 12'd1;
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
